// File: rtl/key_pkg.sv
// Shared types and default timing for the key press detector.
// Counter widths cover the default 50 MHz timing constants.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILT_DN = 2'd1,
      HELD    = 2'd2,
      FILT_UP = 2'd3
   } state_t;

   localparam int unsigned T_DEBOUNCE_DEF     = 1_000_000;
   localparam int unsigned T_LONG_DEF         = 50_000_000;
   localparam int unsigned T_REPEAT_DEF       = 5_000_000;
   localparam int unsigned KEY_ACTIVE_LOW_DEF = 1;

   localparam int unsigned DB_W   = 20;
   localparam int unsigned HOLD_W = 26;
   localparam int unsigned RPT_W  = 23;
   localparam int unsigned CNT_W  = 8;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw key pin, normalised so key_act = 1 means pressed.
// Reset presets both flops to the idle pin level so no false press is seen.
import key_pkg::*;

module key_sync #(
   parameter bit ACTIVE_LOW = (KEY_ACTIVE_LOW_DEF != 0)
) (
   input  logic CLK,
   input  logic RST,
   input  logic key_in,
   output logic key_act
);

   localparam logic IDLE_LVL = ACTIVE_LOW;

   logic sync1_d, sync1_q;
   logic sync2_d, sync2_q;

   always_comb begin
      sync1_d = key_in;
      sync2_d = sync1_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign key_act = sync2_q ^ ACTIVE_LOW;

endmodule

// File: rtl/key_press_detector.sv
// Debounced key detector: level, press/release/long strobes and a wrapping press count.
// Define KEY_AUTO_REPEAT_EN to add the auto-repeat strobe after a long press.
import key_pkg::*;

module key_press_detector #(
   parameter int unsigned T_DEBOUNCE     = T_DEBOUNCE_DEF,
   parameter int unsigned T_LONG         = T_LONG_DEF,
   parameter int unsigned T_REPEAT       = T_REPEAT_DEF,
   parameter int unsigned KEY_ACTIVE_LOW = KEY_ACTIVE_LOW_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             key_in,
   output logic             key_state,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             long_pulse,
   output logic             repeat_pulse,
   output logic [CNT_W-1:0] press_count
);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(T_DEBOUNCE - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(T_LONG - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(T_LONG);

   logic key_act;

   key_sync #(
      .ACTIVE_LOW(KEY_ACTIVE_LOW != 0)
   ) u_sync (
      .CLK    (CLK),
      .RST    (RST),
      .key_in (key_in),
      .key_act(key_act)
   );

   state_t             state_q, state_d;
   logic [DB_W-1:0]    db_q, db_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               key_state_q, key_state_d;
   logic               press_q, press_d;
   logic               release_q, release_d;
   logic               long_q, long_d;

   always_comb begin
      state_d     = state_q;
      db_d        = db_q;
      hold_d      = hold_q;
      count_d     = count_q;
      key_state_d = key_state_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;

      // Hold time keeps accumulating while a release is still being filtered.
      if (state_q == HELD || state_q == FILT_UP) begin
         if (hold_q == HOLD_LAST) long_d = 1'b1;
         if (hold_q != HOLD_SAT)  hold_d = hold_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (key_act) begin
               state_d = FILT_DN;
               db_d    = '0;
            end
         end
         FILT_DN: begin
            if (!key_act) begin
               state_d = IDLE;
            end else if (db_q == DB_LAST) begin
               state_d     = HELD;
               key_state_d = 1'b1;
               press_d     = 1'b1;
               count_d     = count_q + 1'b1;
               hold_d      = '0;
            end else begin
               db_d = db_q + 1'b1;
            end
         end
         HELD: begin
            if (!key_act) begin
               state_d = FILT_UP;
               db_d    = '0;
            end
         end
         FILT_UP: begin
            if (key_act) begin
               state_d = HELD;
            end else if (db_q == DB_LAST) begin
               state_d     = IDLE;
               key_state_d = 1'b0;
               release_d   = 1'b1;
               long_d      = 1'b0;
            end else begin
               db_d = db_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         db_q        <= '0;
         hold_q      <= '0;
         count_q     <= '0;
         key_state_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         db_q        <= db_d;
         hold_q      <= hold_d;
         count_q     <= count_d;
         key_state_q <= key_state_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   assign key_state     = key_state_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign press_count   = count_q;

`ifdef KEY_AUTO_REPEAT_EN
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(T_REPEAT - 1);

   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             repeat_q, repeat_d;

   // Repeats only run once the hold counter has saturated, i.e. after long_pulse.
   always_comb begin
      rpt_d    = rpt_q;
      repeat_d = 1'b0;
      if (long_d || release_d) begin
         rpt_d = '0;
      end else if (state_q == HELD && hold_q == HOLD_SAT) begin
         if (rpt_q == RPT_LAST) begin
            rpt_d    = '0;
            repeat_d = 1'b1;
         end else begin
            rpt_d = rpt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rpt_q    <= '0;
         repeat_q <= 1'b0;
      end else begin
         rpt_q    <= rpt_d;
         repeat_q <= repeat_d;
      end
   end

   assign repeat_pulse = repeat_q;
`else
   // Repeat period has no effect here; the parameter list stays identical across builds.
   assign repeat_pulse = 1'b0 & (T_REPEAT != 0);
`endif

endmodule

// File: tb/tb_key_press_detector.sv
// Directed bench for key_press_detector (T_DEBOUNCE=8, T_LONG=40, T_REPEAT=10, active-low).
// Define KEY_AUTO_REPEAT_EN for both RTL and bench to check the repeat strobe.
module tb_key_press_detector;

   logic       CLK;
   logic       RST;
   logic       key_in;
   logic       key_state;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic [7:0] press_count;

   key_press_detector #(
      .T_DEBOUNCE    (8),
      .T_LONG        (40),
      .T_REPEAT      (10),
      .KEY_ACTIVE_LOW(1)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .key_in       (key_in),
      .key_state    (key_state),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .press_count  (press_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        key;
      int unsigned cycles;
      logic        exp_state;
      int          exp_count;
      int          exp_press;
      int          exp_release;
   } seg_t;

   seg_t segs[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int press_seen = 0, release_seen = 0, long_seen = 0, repeat_seen = 0;
   int last_press_cyc = -1, last_release_cyc = -1, last_long_cyc = -1;
   int first_repeat_cyc = -1, last_repeat_cyc = -1;
   int overlap_err = 0, width_err = 0;
   logic prev_p = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rp = 1'b0;

   function automatic seg_t seg(logic k, int unsigned n, logic st, int cnt, int p, int r);
      seg_t s;
      s.key = k; s.cycles = n; s.exp_state = st;
      s.exp_count = cnt; s.exp_press = p; s.exp_release = r;
      return s;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock: sample just after the edge and log every strobe with its edge index.
   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
      if (press_pulse === 1'b1)   begin press_seen++;   last_press_cyc = cyc;   end
      if (release_pulse === 1'b1) begin release_seen++; last_release_cyc = cyc; end
      if (long_pulse === 1'b1)    begin long_seen++;    last_long_cyc = cyc;    end
      if (repeat_pulse === 1'b1) begin
         repeat_seen++;
         if (first_repeat_cyc < 0) first_repeat_cyc = cyc;
         last_repeat_cyc = cyc;
      end
      if (press_pulse === 1'b1 && release_pulse === 1'b1) overlap_err++;
      if ((press_pulse === 1'b1 && prev_p) || (release_pulse === 1'b1 && prev_r) ||
          (long_pulse === 1'b1 && prev_l) || (repeat_pulse === 1'b1 && prev_rp))
         width_err++;
      prev_p  = (press_pulse === 1'b1);
      prev_r  = (release_pulse === 1'b1);
      prev_l  = (long_pulse === 1'b1);
      prev_rp = (repeat_pulse === 1'b1);
   endtask

   initial begin
      int c0, pc, p0, r0, c1, c2;

      // Pin-level segments; expectations are cumulative after each segment.
      segs.push_back(seg(1'b1,  5, 1'b0, 0, 0, 0));
      segs.push_back(seg(1'b0,  8, 1'b0, 0, 0, 0));  // one short of acceptance
      segs.push_back(seg(1'b1, 12, 1'b0, 0, 0, 0));
      segs.push_back(seg(1'b0,  9, 1'b0, 0, 0, 0));  // minimum accepted press
      segs.push_back(seg(1'b1,  4, 1'b1, 1, 1, 0));
      segs.push_back(seg(1'b1,  6, 1'b1, 1, 1, 0));
      segs.push_back(seg(1'b1,  1, 1'b0, 1, 1, 1));
      segs.push_back(seg(1'b1,  5, 1'b0, 1, 1, 1));
      for (int i = 0; i < 10; i++)
         segs.push_back(seg((i % 2 == 0) ? 1'b0 : 1'b1, 3, 1'b0, 1, 1, 1));
      segs.push_back(seg(1'b1, 20, 1'b0, 1, 1, 1));
      segs.push_back(seg(1'b0, 12, 1'b1, 2, 2, 1));
      segs.push_back(seg(1'b1,  8, 1'b1, 2, 2, 1));  // release glitch
      segs.push_back(seg(1'b0, 10, 1'b1, 2, 2, 1));
      segs.push_back(seg(1'b1, 12, 1'b0, 2, 2, 2));

      key_in = 1'b1;
      RST    = 1'b1;
      step();
      step();
      check("reset outputs", {key_state, press_pulse, release_pulse, long_pulse,
                              repeat_pulse, press_count}, 0);
      RST = 1'b0;

      for (int i = 0; i < segs.size(); i++) begin
         key_in = segs[i].key;
         repeat (segs[i].cycles) step();
         check($sformatf("seg%0d key_state", i), key_state, segs[i].exp_state);
         check($sformatf("seg%0d press_count", i), press_count, segs[i].exp_count);
         check($sformatf("seg%0d presses", i), press_seen, segs[i].exp_press);
         check($sformatf("seg%0d releases", i), release_seen, segs[i].exp_release);
      end

      // Clean press, long press, then release with exact edge timing.
      c0 = cyc; p0 = press_seen;
      key_in = 1'b0;
      for (int i = 0; i < 40 && press_seen == p0; i++) step();
      check("A press seen", press_seen, p0 + 1);
      check("A press edge", last_press_cyc, c0 + 11);
      check("A key_state on press", key_state, 1);
      check("A press_count", press_count, 3);
      step();
      check("A press width", press_pulse, 0);
      pc = last_press_cyc;
      while (cyc < pc + 75) step();
      check("A long count", long_seen, 1);
      check("A long edge", last_long_cyc, pc + 40);
`ifdef KEY_AUTO_REPEAT_EN
      check("A repeat count", repeat_seen, 3);
      check("A first repeat", first_repeat_cyc, pc + 50);
      check("A third repeat", last_repeat_cyc, pc + 70);
`endif
      c1 = cyc; r0 = release_seen;
      key_in = 1'b1;
      for (int i = 0; i < 40 && release_seen == r0; i++) step();
      check("A release seen", release_seen, r0 + 1);
      check("A release edge", last_release_cyc, c1 + 11);
      check("A key_state on release", key_state, 0);
      check("A long once", long_seen, 1);

      // Reset while held: no release, fresh debounce after reset.
      repeat (3) step();
      p0 = press_seen;
      key_in = 1'b0;
      for (int i = 0; i < 40 && press_seen == p0; i++) step();
      check("B press_count before reset", press_count, 4);
      repeat (5) step();
      RST = 1'b1;
      r0 = release_seen;
      step();
      check("B outputs after reset edge", {key_state, press_pulse, release_pulse, long_pulse,
                                           repeat_pulse, press_count}, 0);
      step();
      RST = 1'b0;
      c2 = cyc; p0 = press_seen;
      for (int i = 0; i < 40 && press_seen == p0; i++) step();
      check("B no release through reset", release_seen, r0);
      check("B press seen", press_seen, p0 + 1);
      check("B press edge", last_press_cyc, c2 + 11);
      check("B press_count", press_count, 1);
      check("B key_state", key_state, 1);
      r0 = release_seen;
      key_in = 1'b1;
      for (int i = 0; i < 40 && release_seen == r0; i++) step();
      check("B release seen", release_seen, r0 + 1);

      check("press/release overlap", overlap_err, 0);
      check("strobe width", width_err, 0);
`ifndef KEY_AUTO_REPEAT_EN
      check("repeat stays 0", repeat_seen, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
